// File: rtl/date_entry_if.sv
// Keypad date-entry bus: control inputs, loaded date, status and BCD echo digits.
// Latency: none (wires only).
// Backpressure: none; the key strobe is edge-detected by the consumer.
//
// Ports (modports):
//   master : drives start/key_stb/key_code, observes all outputs.
//   slave  : the date_entry core; consumes control, drives date/status/echo.
interface date_entry_if;
  logic       start;
  logic       key_stb;
  logic [3:0] key_code;
  logic [6:0] year;
  logic [6:0] month;
  logic [6:0] day;
  logic       load_ok;
  logic       load_err;
  logic       busy;
  logic [2:0] pos;
  logic [3:0] e_y10;
  logic [3:0] e_y1;
  logic [3:0] e_m10;
  logic [3:0] e_m1;
  logic [3:0] e_d10;
  logic [3:0] e_d1;

  modport master (
    output start, key_stb, key_code,
    input  year, month, day, load_ok, load_err, busy, pos,
    input  e_y10, e_y1, e_m10, e_m1, e_d10, e_d1
  );

  modport slave (
    input  start, key_stb, key_code,
    output year, month, day, load_ok, load_err, busy, pos,
    output e_y10, e_y1, e_m10, e_m1, e_d10, e_d1
  );
endinterface

// File: rtl/date_entry.sv
// Six-digit YYMMDD keypad entry with validation and load of a held date register.
// Latency: a key takes effect at the edge it is detected; LOAD_OK/LOAD_ERR pulse
//          for the one RESULT cycle, two cycles after the strobe of the 6th digit.
// Backpressure: none; key events outside ENTRY are dropped, START only seen in IDLE.
//
// Ports:
//   clk_i   : system clock, rising edge.
//   reset_i : synchronous active-high reset.
//   bus     : date_entry_if.slave (start, key strobe/code in; date, pulses,
//             busy, pos and BCD echo digits out).
module date_entry (
  input  logic         clk_i,
  input  logic         reset_i,
  date_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    CHECK  = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ABORT = 4'hB;
  localparam int         NDIG      = 6;

  state_t     state_q, state_d;
  logic       key_last_q;
  logic [2:0] pos_q, pos_d;
  // Echo digits in entry order: y10, y1, m10, m1, d10, d1.
  logic [3:0] dig_q [NDIG];
  logic [3:0] dig_d [NDIG];
  logic [6:0] year_q, year_d;
  logic [6:0] month_q, month_d;
  logic [6:0] day_q, day_d;
  logic       load_ok_q, load_ok_d;
  logic       load_err_q, load_err_d;

  logic       key_evt;
  logic       key_is_digit;
  logic [6:0] y_bin, m_bin, d_bin;
  logic [6:0] max_day;
  logic       date_valid;

  // One event per strobe rising edge, however long the strobe is held.
  assign key_evt      = bus.key_stb & ~key_last_q;
  assign key_is_digit = (bus.key_code <= 4'd9);

  // Digits are only ever 0-9, so each two-digit value is at most 99.
  assign y_bin = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
  assign m_bin = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);
  assign d_bin = 7'(dig_q[4]) * 7'd10 + 7'(dig_q[5]);

  // No leap years: February is always 28 days.
  always_comb begin
    max_day = 7'd31;
    case (m_bin)
      7'd2:                        max_day = 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11:     max_day = 7'd30;
      default:                     max_day = 7'd31;
    endcase
  end

  assign date_valid = (y_bin != 7'd0) &&
                      (m_bin >= 7'd1) && (m_bin <= 7'd12) &&
                      (d_bin >= 7'd1) && (d_bin <= max_day);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dig_d      = dig_q;
    year_d     = year_q;
    month_d    = month_q;
    day_d      = day_q;
    load_ok_d  = 1'b0;
    load_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ENTRY;
          pos_d   = 3'd0;
          for (int i = 0; i < NDIG; i++) dig_d[i] = 4'd0;
        end
      end

      ENTRY: begin
        if (key_evt) begin
          if (key_is_digit) begin
            for (int i = 0; i < NDIG; i++) begin
              if (pos_q == 3'(i)) dig_d[i] = bus.key_code;
            end
            pos_d = pos_q + 3'd1;
            if (pos_q == 3'(NDIG - 1)) state_d = CHECK;
          end else if (bus.key_code == KEY_CLEAR) begin
            pos_d = 3'd0;
            for (int i = 0; i < NDIG; i++) dig_d[i] = 4'd0;
          end else if (bus.key_code == KEY_ABORT) begin
            // Echo digits are kept for display; only the entry is dropped.
            state_d = IDLE;
            pos_d   = 3'd0;
          end
          // 4'hC-4'hF fall through unchanged.
        end
      end

      CHECK: begin
        state_d = RESULT;
        if (date_valid) begin
          year_d    = y_bin;
          month_d   = m_bin;
          day_d     = d_bin;
          load_ok_d = 1'b1;
        end else begin
          load_err_d = 1'b1;
        end
      end

      RESULT: begin
        state_d = IDLE;
        pos_d   = 3'd0;
      end

      default: begin
        state_d = IDLE;
        pos_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      key_last_q <= 1'b0;
      pos_q      <= 3'd0;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'd0;
      year_q     <= 7'd20;
      month_q    <= 7'd12;
      day_q      <= 7'd15;
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_last_q <= bus.key_stb;
      pos_q      <= pos_d;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= dig_d[i];
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      load_ok_q  <= load_ok_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.year     = year_q;
  assign bus.month    = month_q;
  assign bus.day      = day_q;
  assign bus.load_ok  = load_ok_q;
  assign bus.load_err = load_err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.pos      = pos_q;
  assign bus.e_y10    = dig_q[0];
  assign bus.e_y1     = dig_q[1];
  assign bus.e_m10    = dig_q[2];
  assign bus.e_m1     = dig_q[3];
  assign bus.e_d10    = dig_q[4];
  assign bus.e_d1     = dig_q[5];

endmodule
